// File: rtl/bram_req_ctrl.sv
// bram_req_ctrl: valid/ready request front end for one native BRAM port.
// Requests are issued on registered BRAM pins. A {write, err} tag rides a
// shift register that matches the BRAM read latency. Completed accesses land
// in an in-order response FIFO. A credit counter caps the number of
// outstanding requests at the FIFO depth, so the FIFO never overflows.
module bram_req_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 262144,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_write,
  output logic                rsp_err,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic                busy
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0]   LAST_P  = PW'(RSP_DEPTH - 1);
  localparam logic [ADDR_W:0] LIM     = (ADDR_W + 1)'(MEM_BYTES);

  typedef struct packed {
    logic              write;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic            acc, pop, addr_err;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            rdy_q;

  assign acc      = req_valid & rdy_q;
  assign pop      = rsp_valid & rsp_ready;
  assign addr_err = {1'b0, req_addr} >= LIM;
  assign req_ready = rdy_q;
  assign busy      = cnt != '0;

  // Credit count: +1 on accept, -1 on pop, unchanged when both happen
  always_comb begin
    cnt_nxt = cnt;
    if (acc && !pop)      cnt_nxt = cnt + 1'b1;
    else if (!acc && pop) cnt_nxt = cnt - 1'b1;
  end

  // Registered credit state; ready comes from the next count so it is never
  // combinational from req_valid, and it stays low through reset
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      cnt   <= '0;
      rdy_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= cnt_nxt < DEPTH_C;
    end
  end

  // Issue: drive BRAM pins for one cycle per in-range accept, else idle
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      mem_en   <= 1'b0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      if (acc && !addr_err) begin
        mem_en   <= 1'b1;
        mem_we   <= req_we ? req_wstrb : '0;
        mem_addr <= {2'b00, req_addr[ADDR_W-1:2]};
        mem_din  <= req_wdata;
      end
    end
  end

  // Tag pipeline: stage 0 lines up with the BRAM pins, stage RD_LAT with mem_dout
  logic [RD_LAT:0] vld_pipe, wr_pipe, err_pipe;
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      vld_pipe <= '0;
      wr_pipe  <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], acc};
      wr_pipe  <= {wr_pipe[RD_LAT-1:0], req_we};
      err_pipe <= {err_pipe[RD_LAT-1:0], addr_err};
    end
  end

  logic push;
  rsp_t push_e;
  assign push = vld_pipe[RD_LAT];

  // Build the response entry; only clean reads carry BRAM data
  always_comb begin
    push_e       = '0;
    push_e.write = wr_pipe[RD_LAT];
    push_e.err   = err_pipe[RD_LAT];
    if (!wr_pipe[RD_LAT] && !err_pipe[RD_LAT]) push_e.rdata = mem_dout;
  end

  rsp_t          fifo_q [RSP_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] fcnt;
  rsp_t          head;

  // FIFO storage; contents are only observed while valid, so no reset needed
  always_ff @(posedge clka) begin
    if (push) fifo_q[wp] <= push_e;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= (wp == LAST_P) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == LAST_P) ? '0 : rp + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (!push && pop) fcnt <= fcnt - 1'b1;
    end
  end

  assign head      = fifo_q[rp];
  assign rsp_valid = fcnt != '0;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_write = rsp_valid & head.write;
  assign rsp_err   = rsp_valid & head.err;

  a_no_ovf: assert property (@(posedge clka) disable iff (rsta)
    !(push && !pop && fcnt == DEPTH_C));
endmodule

// File: tb/tb_bram_req_ctrl.sv
// tb_bram_req_ctrl: directed vectors against a read-first BRAM model.
module tb_bram_req_ctrl;
  logic        clka = 1'b0, rsta = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        busy;

  bram_req_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(262144), .RD_LAT(1), .RSP_DEPTH(4)) dut (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clka = ~clka;

  // Read-first BRAM model, one cycle latency
  logic [31:0] bram [0:65535];
  logic [31:0] bram_dout;
  always @(posedge clka) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr[15:0]][8*b +: 8] <= mem_din[8*b +: 8];
      bram_dout <= bram[mem_addr[15:0]];
    end
  end
  assign mem_dout = bram_dout;

  logic [105:0] all_out;
  assign all_out = {req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err,
                    mem_en, mem_we, mem_addr, mem_din, busy};

  int vec = 0, errs = 0;

  task automatic tick;
    @(posedge clka); #1;
  endtask

  task automatic drive_idle;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset;
    rsta = 1'b0; #2 rsta = 1'b1;
    repeat (3) tick();
    vec++; if (all_out !== '0) begin errs++; $display("FAIL rst_outs: got %h want 0", all_out); end
    rsta = 1'b0;
    #3;
    vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_rdy_early: got %b want 0", req_ready); end
    tick();
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_rdy_late: got %b want 1", req_ready); end
    vec++; if ({busy, rsp_valid, mem_en} !== 3'b000) begin errs++; $display("FAIL rst_idle: got %b want 000", {busy, rsp_valid, mem_en}); end
  endtask

  task automatic test_write_read;
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL wr_rdy: got %b want 1", req_ready); end
    drive_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    vec++; if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'hF, 32'h4, 32'hDEADBEEF}) begin
      errs++; $display("FAIL wr_pins: got %h want %h", {mem_en, mem_we, mem_addr, mem_din}, {1'b1, 4'hF, 32'h4, 32'hDEADBEEF}); end
    drive_req(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    vec++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'h0, 32'h4}) begin
      errs++; $display("FAIL rd_pins: got %h want %h", {mem_en, mem_we, mem_addr}, {1'b1, 4'h0, 32'h4}); end
    drive_idle();
    tick();
    vec++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b110, 32'h0}) begin
      errs++; $display("FAIL wr_rsp: got %h want %h", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {3'b110, 32'h0}); end
    tick();
    vec++; if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      errs++; $display("FAIL rd_rsp_lat3: got %h want %h", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {3'b100, 32'hDEADBEEF}); end
    tick();
    vec++; if ({rsp_valid, busy, mem_en} !== 3'b000) begin errs++; $display("FAIL wr_drain: got %b want 000", {rsp_valid, busy, mem_en}); end
  endtask

  task automatic test_partial;
    bit ok;
    bram[8] = 32'h11223344;
    drive_req(1'b1, 32'h20, 32'h0000AB00, 4'h2);
    tick();
    vec++; if ({mem_en, mem_we} !== 5'b10010) begin errs++; $display("FAIL pw_we: got %b want 10010", {mem_en, mem_we}); end
    drive_idle();
    wait_rsp(ok);
    vec++; if ({ok, rsp_write} !== 2'b11) begin errs++; $display("FAIL pw_rsp: got %b want 11", {ok, rsp_write}); end
    tick();
    drive_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    tick();
    vec++; if ({mem_en, mem_we} !== 5'b10000) begin errs++; $display("FAIL zs_we: got %b want 10000", {mem_en, mem_we}); end
    drive_idle();
    wait_rsp(ok);
    vec++; if ({ok, rsp_write, rsp_err} !== 3'b110) begin errs++; $display("FAIL zs_rsp: got %b want 110", {ok, rsp_write, rsp_err}); end
    tick();
    drive_req(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    drive_idle();
    wait_rsp(ok);
    vec++; if ({ok, rsp_write, rsp_rdata} !== {2'b10, 32'h1122AB44}) begin
      errs++; $display("FAIL pw_rdback: got %h want %h", {ok, rsp_write, rsp_rdata}, {2'b10, 32'h1122AB44}); end
    tick();
  endtask

  task automatic test_backpressure;
    int idx, got;
    logic v, a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) bram[16'h40 + i] = 32'hC0DE0000 + 32'(i);
    rsp_ready = 1'b0;
    idx = 0;
    drive_req(1'b0, 32'h100, 32'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      a = req_valid & req_ready;
      tick();
      if (a) begin idx++; req_addr = 32'h100 + 32'(4 * idx); end
    end
    vec++; if (idx !== 4) begin errs++; $display("FAIL bp_accepts: got %0d want 4", idx); end
    vec++; if ({req_ready, busy, rsp_valid} !== 3'b011) begin errs++; $display("FAIL bp_stall: got %b want 011", {req_ready, busy, rsp_valid}); end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      v = rsp_valid; d = rsp_rdata; a = req_valid & req_ready;
      tick();
      if (v) begin
        vec++; if (d !== 32'hC0DE0000 + 32'(got)) begin errs++; $display("FAIL bp_order%0d: got %h want %h", got, d, 32'hC0DE0000 + 32'(got)); end
        got++;
      end
      if (a) begin
        idx++;
        if (idx < 6) req_addr = 32'h100 + 32'(4 * idx);
        else drive_idle();
      end
    end
    vec++; if (got !== 6 || idx !== 6) begin errs++; $display("FAIL bp_count: got %0d/%0d want 6/6", got, idx); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_busy: got %b want 0", busy); end
  endtask

  task automatic test_range;
    int en_seen;
    bit ok, got;
    logic [33:0] cap;
    drive_req(1'b0, 32'h40000, 32'h0, 4'h0);
    tick();
    drive_idle();
    en_seen = 0; got = 1'b0; cap = '0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (mem_en) en_seen++;
      if (rsp_valid) begin got = 1'b1; cap = {rsp_err, rsp_write, rsp_rdata}; end
      tick();
    end
    vec++; if (en_seen !== 0) begin errs++; $display("FAIL oor_en: got %0d want 0", en_seen); end
    vec++; if ({got, cap} !== {1'b1, 2'b10, 32'h0}) begin errs++; $display("FAIL oor_rsp: got %h want %h", {got, cap}, {1'b1, 2'b10, 32'h0}); end
    drive_req(1'b1, 32'h3FFFC, 32'h55AA55AA, 4'hF);
    tick();
    vec++; if ({mem_en, mem_addr} !== {1'b1, 32'h0000FFFF}) begin errs++; $display("FAIL top_pins: got %h want %h", {mem_en, mem_addr}, {1'b1, 32'h0000FFFF}); end
    drive_idle();
    wait_rsp(ok);
    vec++; if ({ok, rsp_err, rsp_write} !== 3'b101) begin errs++; $display("FAIL top_rsp: got %b want 101", {ok, rsp_err, rsp_write}); end
    tick();
    vec++; if (bram[16'hFFFF] !== 32'h55AA55AA) begin errs++; $display("FAIL top_mem: got %h want 55aa55aa", bram[16'hFFFF]); end
  endtask

  task automatic test_back_to_back;
    int idx, got, drops, first, last;
    logic v, a;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) bram[16'h80 + i] = 32'h5A000000 + 32'(i * 32'h111);
    rsp_ready = 1'b1;
    idx = 0; got = 0; drops = 0; first = -1; last = -1;
    drive_req(1'b0, 32'h200, 32'h0, 4'h0);
    for (int c = 0; c < 30; c++) begin
      if (req_valid && !req_ready) drops++;
      v = rsp_valid; d = rsp_rdata; a = req_valid & req_ready;
      tick();
      if (v) begin
        vec++; if (d !== 32'h5A000000 + 32'(got * 32'h111)) begin
          errs++; $display("FAIL b2b_data%0d: got %h want %h", got, d, 32'h5A000000 + 32'(got * 32'h111)); end
        if (got == 0) first = c;
        last = c;
        got++;
      end
      if (a) begin
        idx++;
        if (idx < 16) req_addr = 32'h200 + 32'(4 * idx);
        else drive_idle();
      end
    end
    vec++; if (drops !== 0) begin errs++; $display("FAIL b2b_ready: got %0d stalls want 0", drops); end
    vec++; if (got !== 16 || last - first !== 15) begin errs++; $display("FAIL b2b_rate: got %0d rsps over %0d want 16 over 15", got, last - first); end
  endtask

  task automatic test_reset_inflight;
    int seen;
    rsp_ready = 1'b0;
    drive_req(1'b0, 32'h10, 32'h0, 4'h0); tick();
    req_addr = 32'h14; tick();
    req_addr = 32'h18; tick();
    drive_idle();
    rsta = 1'b1;
    #1;
    vec++; if (all_out !== '0) begin errs++; $display("FAIL ri_outs0: got %h want 0", all_out); end
    tick();
    vec++; if (all_out !== '0) begin errs++; $display("FAIL ri_outs1: got %h want 0", all_out); end
    rsta = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (rsp_valid) seen++; end
    vec++; if (seen !== 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errs++; $display("FAIL ri_quiet: got rsps=%0d busy=%b rdy=%b want 0 0 1", seen, busy, req_ready); end
    drive_req(1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    drive_idle();
    tick(); tick();
    vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errs++; $display("FAIL ri_next: got %h want %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hDEADBEEF}); end
    tick();
    vec++; if ({rsp_valid, busy} !== 2'b00) begin errs++; $display("FAIL ri_drain: got %b want 00", {rsp_valid, busy}); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) bram[i] = '0;
    bram_dout = '0;
    drive_idle();
    rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_partial();
    test_backpressure();
    test_range();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
